fib_pair_gen: RTL and testbench

FIB_PAIR_GEN -- requirements
Module: fib_pair_gen

---
 rtl/fib_pair_gen.sv | 90 +++++++++
 tb/tb_fib_pair_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fib_pair_gen.sv
// Fibonacci-pair generator: a three-state run controller that adds x+y into x or y each step.
// Optional macro FIB_SAT_EN saturates the updated accumulator on carry-out instead of wrapping.
module fib_pair_gen #(
  parameter int WIDTH     = 11,
  parameter int MAX_STEPS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           selector,
  input  logic                           hold,
  output logic [WIDTH-1:0]               x,
  output logic [WIDTH-1:0]               y,
  output logic [WIDTH-1:0]               i,
  output logic [WIDTH-1:0]               j,
  output logic [$clog2(MAX_STEPS+1)-1:0] steps,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);
  localparam int SW = $clog2(MAX_STEPS+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  // One extra bit so the carry-out is visible to the overflow flag.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] upd;
  assign sum = {1'b0, x} + {1'b0, y};

`ifdef FIB_SAT_EN
  assign upd = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
  assign upd = sum[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      i        <= '0;
      j        <= '0;
      steps    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            x        <= WIDTH'(1);
            y        <= WIDTH'(1);
            i        <= '0;
            j        <= '0;
            steps    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          if (!hold) begin
            if (selector) begin
              x <= upd;
              i <= i + WIDTH'(1);
            end else begin
              y <= upd;
              j <= j + WIDTH'(1);
            end
            if (sum[WIDTH]) overflow <= 1'b1;
            steps <= steps + SW'(1);
            // Final step retires the run on the same edge it lands.
            if (steps == SW'(MAX_STEPS-1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fib_pair_gen.sv
// Bench for fib_pair_gen: two instances (11-bit/4 steps, 4-bit/6 steps) checked each cycle
// against an arithmetic reference model, plus directed scenario values and a random phase.
module tb_fib_pair_gen;
  logic clk = 1'b0;
  logic rst, start, selector, hold;

  logic [10:0] a_x, a_y, a_i, a_j;
  logic [2:0]  a_steps;
  logic        a_busy, a_done, a_ovf;
  logic [3:0]  b_x, b_y, b_i, b_j;
  logic [2:0]  b_steps;
  logic        b_busy, b_done, b_ovf;

  int total  = 0;
  int passed = 0;

`ifdef FIB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  fib_pair_gen #(.WIDTH(11), .MAX_STEPS(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .selector(selector), .hold(hold),
    .x(a_x), .y(a_y), .i(a_i), .j(a_j), .steps(a_steps),
    .busy(a_busy), .done(a_done), .overflow(a_ovf));

  fib_pair_gen #(.WIDTH(4), .MAX_STEPS(6)) dut_b (
    .clk(clk), .rst(rst), .start(start), .selector(selector), .hold(hold),
    .x(b_x), .y(b_y), .i(b_i), .j(b_j), .steps(b_steps),
    .busy(b_busy), .done(b_done), .overflow(b_ovf));

  // phase: 0 idle, 1 running, 2 finished
  typedef struct {
    int x, y, i, j, steps, phase;
    bit ovf;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, int w, int maxs, bit r, bit st, bit sl, bit h);
    mdl_t n = m;
    int lim = 1 << w;
    int s;
    if (!r) begin
      n = '{default:0};
    end else if (m.phase != 1) begin
      if (st) begin
        n.x = 1; n.y = 1; n.i = 0; n.j = 0; n.steps = 0; n.ovf = 0; n.phase = 1;
      end
    end else if (!h) begin
      s = m.x + m.y;
      if (s >= lim) begin
        n.ovf = 1;
        s = SAT ? lim - 1 : s - lim;
      end
      if (sl) begin n.x = s; n.i = m.i + 1; end
      else    begin n.y = s; n.j = m.j + 1; end
      n.steps = m.steps + 1;
      if (n.steps == maxs) n.phase = 2;
    end
    return n;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_model();
    chk("a.x", int'(a_x), ma.x);          chk("a.y", int'(a_y), ma.y);
    chk("a.i", int'(a_i), ma.i);          chk("a.j", int'(a_j), ma.j);
    chk("a.steps", int'(a_steps), ma.steps);
    chk("a.busy", int'(a_busy), int'(ma.phase == 1));
    chk("a.done", int'(a_done), int'(ma.phase == 2));
    chk("a.ovf", int'(a_ovf), int'(ma.ovf));
    chk("a.inv", int'(a_i) + int'(a_j), int'(a_steps));
    chk("b.x", int'(b_x), mb.x);          chk("b.y", int'(b_y), mb.y);
    chk("b.i", int'(b_i), mb.i);          chk("b.j", int'(b_j), mb.j);
    chk("b.steps", int'(b_steps), mb.steps);
    chk("b.busy", int'(b_busy), int'(mb.phase == 1));
    chk("b.done", int'(b_done), int'(mb.phase == 2));
    chk("b.ovf", int'(b_ovf), int'(mb.ovf));
    chk("b.inv", (int'(b_i) + int'(b_j)) % 16, int'(b_steps));
  endtask

  // Advance the models with the inputs present before the edge, then compare 1 time unit after it.
  task automatic tick();
    ma = mstep(ma, 11, 4, rst, start, selector, hold);
    mb = mstep(mb, 4, 6, rst, start, selector, hold);
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic step(bit sl, bit h);
    selector = sl; hold = h; tick();
  endtask

  initial begin
    ma = '{default:0};
    mb = '{default:0};
    rst = 1'b0; start = 1'b0; selector = 1'b0; hold = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst.a_x", int'(a_x), 0);
    chk("rst.a_busy", int'(a_busy), 0);
    chk("rst.b_done", int'(b_done), 0);

    // Selector-1 run on the 4-step instance
    rst = 1'b1; start = 1'b1; tick(); start = 1'b0;
    step(1, 0); step(1, 0); step(1, 0);
    chk("sel1.done_early", int'(a_done), 0);
    step(1, 0);
    chk("sel1.x", int'(a_x), 5);       chk("sel1.y", int'(a_y), 1);
    chk("sel1.i", int'(a_i), 4);       chk("sel1.j", int'(a_j), 0);
    chk("sel1.steps", int'(a_steps), 4);
    chk("sel1.done", int'(a_done), 1);

    // Restart from DONE with hold high still loads
    start = 1'b1; hold = 1'b1; tick(); start = 1'b0; hold = 1'b0;
    chk("restart.x", int'(a_x), 1);    chk("restart.y", int'(a_y), 1);
    chk("restart.i", int'(a_i), 0);    chk("restart.ovf", int'(a_ovf), 0);
    chk("restart.busy", int'(a_busy), 1);

    // Alternating selector
    step(1, 0); step(0, 0); step(1, 0); step(0, 0);
    chk("alt.x", int'(a_x), 5);        chk("alt.y", int'(a_y), 8);
    chk("alt.i", int'(a_i), 2);        chk("alt.j", int'(a_j), 2);
    chk("alt.ovf", int'(a_ovf), 0);    chk("alt.done", int'(a_done), 1);

    // Overflow on the 4-bit instance
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 6; k++) step(k % 2 == 0, 0);
    chk("ovf.x", int'(b_x), 13);
    chk("ovf.y", int'(b_y), SAT ? 15 : 5);
    chk("ovf.flag", int'(b_ovf), 1);
    chk("ovf.done", int'(b_done), 1);
    step(0, 0);
    chk("ovf.done_hold_y", int'(b_y), SAT ? 15 : 5);

    // Hold on cycles 2-3 delays DONE by two; start mid-run is ignored
    start = 1'b1; tick(); start = 1'b0;
    step(1, 0); step(0, 1); step(1, 1);
    chk("hold.steps", int'(a_steps), 1);
    start = 1'b1; step(0, 0); start = 1'b0;
    chk("hold.noreload_y", int'(a_y), 3);
    step(1, 0);
    chk("hold.done_early", int'(a_done), 0);
    step(0, 0);
    chk("hold.done", int'(a_done), 1);
    chk("hold.x", int'(a_x), 5);       chk("hold.y", int'(a_y), 8);

    // Reset mid-run aborts; a fresh start is needed
    start = 1'b1; tick(); start = 1'b0;
    step(1, 0); step(0, 0);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("abort.x", int'(a_x), 0);      chk("abort.busy", int'(a_busy), 0);
    tick();
    chk("abort.idle", int'(a_busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    step(1, 0); step(0, 0); step(1, 0); step(0, 0);
    chk("rerun.x", int'(a_x), 5);      chk("rerun.y", int'(a_y), 8);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 49) != 0);
      start    = ($urandom_range(0, 5) == 0);
      selector = 1'($urandom_range(0, 1));
      hold     = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
